dmem_store_buffer: RTL and testbench

- Posted-write store buffer between the single-cycle core's data port (memwrite/dataadr/writedata) and the data memory.
- Core stores are queued in a small FIFO and drained to memory under a ready handshake, so a slow memory stalls the core only when the buffer is full.
- Core loads check the buffer first and forward the youngest matching store, so read-after-write ordering is preserved.

---
 rtl/stb_pkg.sv | 11 +
 rtl/stb_match.sv | 28 ++
 rtl/dmem_store_buffer.sv | 81 ++++++++
 tb/tb_dmem_store_buffer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/stb_pkg.sv
// stb_pkg: shared constants and entry type for the dmem store buffer.
package stb_pkg;
    localparam int STB_DEPTH  = 4;
    localparam int STB_PTR_W  = $clog2(STB_DEPTH);
    localparam int STB_ADDR_W = 32;
    localparam int STB_DATA_W = 32;
    typedef struct packed {
        logic [STB_ADDR_W-3:0] waddr;
        logic [STB_DATA_W-1:0] data;
    } stb_entry_t;
endpackage

// File: rtl/stb_match.sv
// stb_match: youngest-first word-address match over the store buffer entries.
module stb_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 30
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][AW-1:0] waddr,
    input  logic [AW-1:0]            key,
    input  logic [$clog2(DEPTH)-1:0] tail,
    output logic                     hit,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] s;
    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        s   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            s = tail - PW'(k);
            if (valid[s] && waddr[s] == key) begin
                hit = 1'b1;
                idx = s;
            end
        end
    end
endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write FIFO between core data port and data memory with load forwarding.
// STB_COALESCE_EN: stores hitting a buffered word overwrite it in place. ADDR_W/DATA_W must match stb_pkg.
module dmem_store_buffer
    import stb_pkg::*;
#(
    parameter int DEPTH  = STB_DEPTH,
    parameter int ADDR_W = STB_ADDR_W,
    parameter int DATA_W = STB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    stb_entry_t                       ent [DEPTH];
    logic [PW-1:0]                    head, tail, hit_idx;
    logic [PW:0]                      count;
    logic [DEPTH-1:0]                 valid;
    logic [DEPTH-1:0][ADDR_W-3:0]     waddrs;
    logic                             full, pop, hit, coal, alloc;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign valid[i]  = {1'b0, PW'(i) - head} < count;
        assign waddrs[i] = ent[i].waddr;
    end

    stb_match #(.DEPTH(DEPTH), .AW(ADDR_W-2)) u_match (
        .valid (valid),
        .waddr (waddrs),
        .key   (dataadr[ADDR_W-1:2]),
        .tail  (tail),
        .hit   (hit),
        .idx   (hit_idx)
    );

    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign mem_we = !empty;
    assign pop   = mem_we & mem_wready;
`ifdef STB_COALESCE_EN
    // A head entry leaving this cycle can no longer absorb the store.
    assign coal  = memwrite & hit & !(pop & hit_idx == head);
`else
    assign coal  = 1'b0;
`endif
    assign alloc = memwrite & !coal & (!full | pop);
    assign stall = memwrite & !coal & full & !pop;
    assign mem_waddr = {ent[head].waddr, 2'b00};
    assign mem_wdata = ent[head].data;
    assign mem_raddr = dataadr;
    assign readdata  = (memread && hit) ? ent[hit_idx].data : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (PW+1)'(alloc) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) ent[tail] <= '{waddr: dataadr[ADDR_W-1:2], data: writedata};
        else if (coal) ent[hit_idx].data <= writedata;
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed checks of queuing, stall, forwarding, coalescing and async reset.
module tb_dmem_store_buffer;
    logic        clk = 1'b0;
    logic        reset, memwrite, memread, mem_wready;
    logic [31:0] dataadr, writedata, mem_rdata;
    logic [31:0] readdata, mem_waddr, mem_wdata, mem_raddr;
    logic        stall, mem_we, empty;
    int          total = 0, passed = 0;

    dmem_store_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .memread    (memread),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .readdata   (readdata),
        .stall      (stall),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    logic [31:0] exp_a [4] = '{32'h4, 32'h8, 32'hC, 32'h10};

    initial begin
        reset = 1'b1; memwrite = 1'b0; memread = 1'b0; mem_wready = 1'b1;
        dataadr = '0; writedata = '0; mem_rdata = '0;
        tick();
        reset = 1'b0;
        #1;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);

        memwrite = 1'b1; dataadr = 32'h8; writedata = 32'h4;
        #1;
        check("sw_stall", 32'(stall), 32'd0);
        check("sw_we_pre", 32'(mem_we), 32'd0);
        tick();
        memwrite = 1'b0;
        #1;
        check("sw_we", 32'(mem_we), 32'd1);
        check("sw_addr", mem_waddr, 32'h8);
        check("sw_data", mem_wdata, 32'h4);
        tick();
        check("sw_empty", 32'(empty), 32'd1);
        check("sw_we_off", 32'(mem_we), 32'd0);

        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            memwrite = 1'b1; dataadr = 32'(i * 4); writedata = 32'h11 + 32'(i);
            #1;
            check("fill_stall", 32'(stall), 32'd0);
            tick();
        end
        dataadr = 32'h10; writedata = 32'h15;
        #1;
        check("full_stall", 32'(stall), 32'd1);
        tick();
        check("full_stall_hold", 32'(stall), 32'd1);
        check("full_head_addr", mem_waddr, 32'h0);
        check("full_head_data", mem_wdata, 32'h11);
        mem_wready = 1'b1;
        #1;
        check("full_pop_stall", 32'(stall), 32'd0);
        tick();
        memwrite = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("drain_we", 32'(mem_we), 32'd1);
            check("drain_addr", mem_waddr, exp_a[j]);
            check("drain_data", mem_wdata, 32'h12 + 32'(j));
            tick();
        end
        check("drain_empty", 32'(empty), 32'd1);

        mem_wready = 1'b0;
        store(32'h20, 32'hAA);
        store(32'h20, 32'hBB);
        memread = 1'b1; dataadr = 32'h20; mem_rdata = 32'h55;
        #1;
        check("fwd_young", readdata, 32'hBB);
        dataadr = 32'h24;
        #1;
        check("fwd_miss", readdata, 32'h55);
        check("raddr", mem_raddr, 32'h24);
        memread = 1'b0; dataadr = 32'h20;
        #1;
        check("no_read", readdata, 32'h55);
`ifdef STB_COALESCE_EN
        check("coal_head", mem_wdata, 32'hBB);
        mem_wready = 1'b1;
        tick();
        check("coal_empty", 32'(empty), 32'd1);
`else
        check("dup_head", mem_wdata, 32'hAA);
        mem_wready = 1'b1;
        tick();
        check("dup_second", mem_wdata, 32'hBB);
        check("dup_second_we", 32'(mem_we), 32'd1);
        tick();
        check("dup_empty", 32'(empty), 32'd1);
`endif

        mem_wready = 1'b0;
        store(32'h60, 32'h1);
        store(32'h64, 32'h2);
        check("pre_rst_we", 32'(mem_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_we", 32'(mem_we), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        tick();
        reset = 1'b0;
        mem_wready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("post_rst_we", 32'(mem_we), 32'd0);
        end

        mem_wready = 1'b0;
        store(32'h3, 32'h7);
        check("unal_addr", mem_waddr, 32'h0);
        memread = 1'b1; dataadr = 32'h1; mem_rdata = 32'h99;
        #1;
        check("unal_fwd", readdata, 32'h7);
        memread = 1'b0;
        mem_wready = 1'b1;
        tick();
        check("unal_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
